lsr_ctrl: RTL
=============

Name: lsr_ctrl

Overview:
- Sequenced 4-bit left shift register; the opposite-direction companion to the team's right-shift register.
- Loads a parallel word, then shifts it left by a programmable count, one bit per clock.
- Fills from a serial input and emits the evicted MSBs on a serial output.
- Signals progress with a busy/done handshake to an upstream controller.

Parameters:
- WIDTH, 4, register width in bits (>=2).
- CNT_W, 3, width of shift-amount field; max shift = 2^CNT_W-1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request: load d and shift by shamt; honoured only in IDLE
- d  input  WIDTH  parallel load word, sampled on accepted start
- shamt  input  CNT_W  shift count, sampled on accepted start
- sin  input  1  serial fill bit, sampled every SHIFT edge that performs a shift
- q  output  WIDTH  register contents (reg)
- sout  output  1  last bit shifted out of q[WIDTH-1] (reg)
- busy  output  1  high while in SHIFT state (reg)
- done  output  1  one-cycle pulse on completion (reg)

Behaviour:
- Clock and reset: single clock domain, clk rising edge; reset is synchronous and active-high on rst.
- Reset, sampled on a clk edge with rst=1:
  - q=0, sout=0, busy=0, done=0, shift counter=0, state=IDLE.
  - Reset overrides start and aborts any operation in progress, including mid-SHIFT and the DONE cycle; no done pulse is generated.
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1, done=0.
  - DONE: busy=0, done=1.
  - busy and done are registered decodes of the next state, so they change on the same edge as the state.
- IDLE:
  - start=1 at edge E0: q<=d, cnt<=shamt, state->SHIFT; sout holds its value.
  - start=0: all outputs hold.
- SHIFT, each edge:
  - cnt!=0: q<={q[WIDTH-2:0], sin}; sout<=q[WIDTH-1]; cnt<=cnt-1; stay in SHIFT.
  - cnt==0: no shift, q and sout hold, state->DONE.
- DONE: one cycle only; state->IDLE next edge; q and sout hold.
- Latency: shamt=N accepted at edge E0.
  - Shifts occur at edges E1..EN.
  - busy is high after E0 through EN.
  - done is high for exactly one cycle after edge E(N+1).
  - Total start-to-done = N+1 edges.
- shamt=0: q loads d, busy high for one cycle, done after E1, q=d unchanged.
- shamt>=WIDTH: legal; shifting continues, q fills entirely with sin history, sout streams all original bits then sin bits.
- start while busy or in DONE: ignored; no queueing; d and shamt are not sampled.
- start asserted in the same cycle done is high (state DONE): ignored; controller must re-assert in IDLE.
- q holds its final value in IDLE until the next accepted start or reset.
- No combinational paths from inputs to outputs.

Test Plan:
- Reset: rst=1 for 2 edges with start=1, d=4'hF -> q=0, sout=0, busy=0, done=0; no load occurs.
- Basic shift: d=4'b1011, shamt=2, sin=0, start one cycle -> after E0 q=1011, busy=1; E1 q=0110, sout=1; E2 q=1100, sout=0; done=1 only in the cycle after E3; busy=0 from E3.
- Serial fill: d=4'b0000, shamt=4, sin=1 every cycle -> q=0001,0011,0111,1111 after E1..E4; sout=0 throughout; done after E5.
- Zero and overlong shift:
  - shamt=0, d=4'hA -> q=1010, busy one cycle, done after E1.
  - shamt=7, d=4'hA, sin=0 -> sout sequence 1,0,1,0,0,0,0; final q=0000; done after E8.
- Ignored start: during shamt=3 operation, pulse start with d=4'h5 at E2 and at the DONE cycle -> no reload; result equals uninterrupted run; next IDLE start is accepted.
- Reset mid-operation: rst=1 at E2 of a shamt=5 run -> q=0, busy=0, done never pulses; fresh start afterwards behaves normally.

Source files
------------

// File: rtl/lsr_ctrl.sv
// lsr_ctrl: sequenced left shift register with start/busy/done handshake.
// A start in IDLE loads d and a shift count; the register then shifts left
// one bit per clock, filling from sin and emitting evicted MSBs on sout.
module lsr_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] d,
  input  logic [CNT_W-1:0] shamt,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q,     q_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             sout_q,  sout_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  // Next-state and datapath update; busy/done decode the next state so they
  // move on the same edge as the state register.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    sout_d  = sout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          q_d     = d;
          cnt_d   = shamt;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          q_d     = {q_q[WIDTH-2:0], sin};
          sout_d  = q_q[WIDTH-1];
          cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset that aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      q_q     <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
